// File: rtl/tsp_pkg.sv
// Shared definitions for the TS output path: packet size, arbiter state
// encoding and a constant-width helper.
package tsp_pkg;

  localparam int PACK_BYTE_SIZE = 188;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  // Smallest width able to hold values 0..value-1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/tsp_prio_pick.sv
// Combinational highest-index-set selector; returns 0 when no request is set.
module tsp_prio_pick #(
  parameter int NUM_CH = 18,
  parameter int IDX_W  = 5
) (
  input  logic [NUM_CH-1:0] req,
  output logic [IDX_W-1:0]  index
);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    index = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (req[k]) index = IDX_W'(k);
    end
  end

endmodule

// File: rtl/tsp_out_arbiter.sv
// Packet-boundary scheduler sharing ts_out between the base stream (ch 0)
// and the replacer channels; ownership changes only at a channel-0 sync.
module tsp_out_arbiter #(
  parameter int NUM_CH         = 18,
  parameter int PACK_BYTE_SIZE = tsp_pkg::PACK_BYTE_SIZE,
  parameter int IDX_W          = 5,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_CH-1:0]     ch_matched,
  input  logic [NUM_CH-1:0]     ch_valid,
  input  logic [NUM_CH-1:0]     ch_sync,
  input  logic [NUM_CH*8-1:0]   ch_data,
  input  logic                  clear_counters,
  output logic                  ts_out_valid,
  output logic                  ts_out_sync,
  output logic [7:0]            ts_out,
  output logic [IDX_W-1:0]      grant_index,
  output logic                  grant_locked,
  output logic [CNT_WIDTH-1:0]  packet_count,
  output logic [CNT_WIDTH-1:0]  short_packet_count,
  output logic [CNT_WIDTH-1:0]  long_packet_count
);
  import tsp_pkg::*;

  localparam int              BC_W = clog2(PACK_BYTE_SIZE + 1);
  localparam logic [BC_W-1:0] FULL = BC_W'(PACK_BYTE_SIZE);

  state_e            state, state_nxt;
  logic [BC_W-1:0]   byte_cnt, byte_cnt_nxt;
  logic [IDX_W-1:0]  grant_nxt, winner, sel;
  logic [NUM_CH-1:0] pick_req;
  logic              sync_evt, fwd, inc_pkt, inc_short, inc_long;
  logic [7:0]        sel_data;
  logic              sel_valid, sel_sync;

  // Channel 0 always loses to any matched replacer, so it never enters the pick.
  assign pick_req = ch_matched & ~{{(NUM_CH-1){1'b0}}, 1'b1};

  tsp_prio_pick #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_pick (
    .req   (pick_req),
    .index (winner)
  );

  assign sync_evt     = ch_valid[0] & ch_sync[0];
  assign sel          = sync_evt ? winner : grant_index;
  assign grant_locked = (state == LOCKED);

  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_sync  = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (sel == IDX_W'(k)) begin
        sel_data  = ch_data[8*k +: 8];
        sel_valid = ch_valid[k];
        sel_sync  = ch_sync[k];
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant_index;
    byte_cnt_nxt = byte_cnt;
    fwd          = 1'b0;
    inc_pkt      = 1'b0;
    inc_short    = 1'b0;
    inc_long     = 1'b0;
    case (state)
      HUNT: begin
        if (sync_evt) begin
          state_nxt    = LOCKED;
          grant_nxt    = winner;
          byte_cnt_nxt = BC_W'(1);
          fwd          = 1'b1;
        end
      end
      LOCKED: begin
        if (sync_evt) begin
          inc_pkt      = (byte_cnt == FULL);
          inc_short    = (byte_cnt != FULL);
          grant_nxt    = winner;
          byte_cnt_nxt = BC_W'(1);
          fwd          = 1'b1;
        end else if (ch_valid[0]) begin
          if (byte_cnt == FULL) begin
            // A full packet with no following sync: keep it, then drop sync.
            inc_pkt   = 1'b1;
            inc_long  = 1'b1;
            state_nxt = HUNT;
          end else begin
            byte_cnt_nxt = byte_cnt + BC_W'(1);
            fwd          = 1'b1;
          end
        end
      end
      default: state_nxt = HUNT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= HUNT;
      byte_cnt     <= '0;
      grant_index  <= '0;
      ts_out_valid <= 1'b0;
      ts_out_sync  <= 1'b0;
      ts_out       <= '0;
    end else begin
      state        <= state_nxt;
      byte_cnt     <= byte_cnt_nxt;
      grant_index  <= grant_nxt;
      ts_out_valid <= fwd & sel_valid;
      ts_out_sync  <= fwd & sel_sync;
      ts_out       <= fwd ? sel_data : 8'h00;
    end
  end

  // Saturating statistics; a clear in the same cycle wins over an increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      packet_count       <= '0;
      short_packet_count <= '0;
      long_packet_count  <= '0;
    end else if (clear_counters) begin
      packet_count       <= '0;
      short_packet_count <= '0;
      long_packet_count  <= '0;
    end else begin
      if (inc_pkt && packet_count != '1)
        packet_count <= packet_count + CNT_WIDTH'(1);
      if (inc_short && short_packet_count != '1)
        short_packet_count <= short_packet_count + CNT_WIDTH'(1);
      if (inc_long && long_packet_count != '1)
        long_packet_count <= long_packet_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_tsp_out_arbiter.sv
// Randomized bench for tsp_out_arbiter: a packet-level reference model is
// compared with the DUT every cycle, plus directed literal checkpoints.
module tb_tsp_out_arbiter;

  localparam int NUM_CH = 18;
  localparam int PKT    = 188;
  localparam int IDX_W  = 5;
  localparam int CW     = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NUM_CH-1:0] ch_matched = '0;
  logic [NUM_CH-1:0] ch_valid = '0;
  logic [NUM_CH-1:0] ch_sync = '0;
  logic [NUM_CH*8-1:0] ch_data;
  logic              clear_counters = 1'b0;
  logic              ts_out_valid, ts_out_sync, grant_locked;
  logic [7:0]        ts_out;
  logic [IDX_W-1:0]  grant_index;
  logic [CW-1:0]     packet_count, short_packet_count, long_packet_count;

  logic [7:0] dat [NUM_CH];

  always_comb begin
    ch_data = '0;
    for (int k = 0; k < NUM_CH; k++) ch_data[8*k +: 8] = dat[k];
  end

  always #5 clk = ~clk;

  tsp_out_arbiter dut (
    .clk(clk), .rst_n(rst_n), .ch_matched(ch_matched), .ch_valid(ch_valid),
    .ch_sync(ch_sync), .ch_data(ch_data), .clear_counters(clear_counters),
    .ts_out_valid(ts_out_valid), .ts_out_sync(ts_out_sync), .ts_out(ts_out),
    .grant_index(grant_index), .grant_locked(grant_locked),
    .packet_count(packet_count), .short_packet_count(short_packet_count),
    .long_packet_count(long_packet_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks who owns the current packet and how many valid
  // bytes of it have been seen, and what the output must show after each edge.
  bit     m_locked = 0;
  int     m_owner = 0;
  int     m_bytes = 0;
  longint m_pkt = 0, m_short = 0, m_long = 0;
  bit     e_valid = 0, e_sync = 0;
  int     e_data = 0;

  function automatic longint sat(input longint v);
    return (v > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_locked = 0; m_owner = 0; m_bytes = 0;
      m_pkt = 0; m_short = 0; m_long = 0;
      e_valid = 0; e_sync = 0; e_data = 0;
    end else begin
      bit is_sync;
      int win;
      is_sync = ch_valid[0] && ch_sync[0];
      win = 0;
      for (int k = 1; k < NUM_CH; k++) if (ch_matched[k]) win = k;
      e_valid = 0; e_sync = 0; e_data = 0;
      if (is_sync) begin
        if (m_locked) begin
          if (m_bytes == PKT) m_pkt++; else m_short++;
        end
        m_locked = 1; m_owner = win; m_bytes = 1;
        e_valid = ch_valid[win]; e_sync = ch_sync[win]; e_data = dat[win];
      end else if (m_locked && ch_valid[0]) begin
        if (m_bytes == PKT) begin
          m_pkt++; m_long++; m_locked = 0;
        end else begin
          m_bytes++;
          e_valid = ch_valid[m_owner]; e_sync = ch_sync[m_owner]; e_data = dat[m_owner];
        end
      end
      if (clear_counters) begin
        m_pkt = 0; m_short = 0; m_long = 0;
      end
    end
  end

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      check("valid", ts_out_valid, e_valid);
      check("sync", ts_out_sync, e_sync);
      if (e_valid) check("data", ts_out, e_data);
      check("locked", grant_locked, m_locked);
      if (m_locked) check("grant", grant_index, m_owner);
      check("pkt_cnt", packet_count, sat(m_pkt));
      check("short_cnt", short_packet_count, sat(m_short));
      check("long_cnt", long_packet_count, sat(m_long));
    end
  end

  // Applies one input cycle (all channels aligned to ch0) and waits for its output.
  task automatic byte_cyc(input bit v, input bit s, input logic [NUM_CH-1:0] m);
    ch_matched = m;
    ch_valid   = {NUM_CH{v}};
    ch_sync    = {NUM_CH{s}};
    for (int k = 0; k < NUM_CH; k++) dat[k] = 8'($urandom);
    @(negedge clk);
  endtask

  function automatic logic [NUM_CH-1:0] sparse_mask();
    return NUM_CH'($urandom) & NUM_CH'($urandom) & NUM_CH'($urandom);
  endfunction

  task automatic body(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) byte_cyc(1'b0, 1'($urandom_range(0, 1)), sparse_mask());
      byte_cyc(1'b1, 1'b0, sparse_mask());
    end
  endtask

  task automatic packet(input int n, input logic [NUM_CH-1:0] m, input bit gaps);
    byte_cyc(1'b1, 1'b1, m);
    body(n - 1, gaps);
  endtask

  logic [NUM_CH-1:0] m317;

  initial begin
    for (int k = 0; k < NUM_CH; k++) dat[k] = '0;
    repeat (3) @(negedge clk);
    check("rst_valid", ts_out_valid, 0);
    check("rst_out", ts_out, 0);
    check("rst_grant", grant_index, 0);
    check("rst_locked", grant_locked, 0);
    check("rst_pkt", packet_count, 0);
    rst_n = 1'b1;
    byte_cyc(1'b0, 1'b0, '0);

    // Base stream only
    packet(PKT, '0, 0);
    packet(PKT, '0, 0);
    packet(PKT, '0, 0);
    check("base_pkt2", packet_count, 2);
    check("base_grant", grant_index, 0);
    byte_cyc(1'b1, 1'b1, '0);
    check("base_pkt3", packet_count, 3);
    body(PKT - 1, 0);

    // Priority: ch17 beats ch3 and holds the packet
    m317 = '0; m317[3] = 1'b1; m317[17] = 1'b1;
    byte_cyc(1'b1, 1'b1, m317);
    check("prio_grant17", grant_index, 17);
    check("prio_pkt4", packet_count, 4);
    body(PKT - 1, 0);
    check("prio_hold17", grant_index, 17);
    byte_cyc(1'b1, 1'b1, NUM_CH'(1 << 3));
    check("prio_grant3", grant_index, 3);
    check("prio_pkt5", packet_count, 5);

    // Short packet: 100 bytes then sync
    body(99, 0);
    byte_cyc(1'b1, 1'b1, NUM_CH'(1 << 9));
    check("short_cnt1", short_packet_count, 1);
    check("short_pkt5", packet_count, 5);
    check("short_grant9", grant_index, 9);
    check("short_cont", ts_out_valid, 1);

    // Long packet: 189 valid bytes
    body(PKT - 1, 0);
    body(1, 0);
    check("long_cnt1", long_packet_count, 1);
    check("long_pkt6", packet_count, 6);
    check("long_valid0", ts_out_valid, 0);
    check("long_unlocked", grant_locked, 0);
    body(5, 0);
    byte_cyc(1'b1, 1'b1, '0);
    check("long_resume", ts_out_valid, 1);
    check("long_relock", grant_locked, 1);

    // Gapped valid: accepted at exactly 188 valid bytes
    body(PKT - 1, 1);
    byte_cyc(1'b1, 1'b1, '0);
    check("gap_pkt7", packet_count, 7);
    check("gap_short1", short_packet_count, 1);

    // Clear coincident with a packet completion
    body(PKT - 1, 0);
    clear_counters = 1'b1;
    byte_cyc(1'b1, 1'b1, '0);
    clear_counters = 1'b0;
    check("clr_pkt0", packet_count, 0);
    check("clr_short0", short_packet_count, 0);
    check("clr_long0", long_packet_count, 0);

    // Randomized traffic
    for (int p = 0; p < 25; p++) begin
      int r;
      r = $urandom_range(0, 11);
      if (r == 10) begin
        clear_counters = 1'b1;
        byte_cyc(1'b0, 1'b0, '0);
        clear_counters = 1'b0;
      end
      if (r < 6)       packet(PKT, sparse_mask(), 0);
      else if (r == 6) packet($urandom_range(1, PKT - 1), sparse_mask(), 0);
      else if (r == 7) packet(PKT + $urandom_range(1, 6), sparse_mask(), 0);
      else if (r == 8) packet(PKT, sparse_mask(), 1);
      else             packet(PKT, (r == 9) ? '0 : sparse_mask(), 0);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) byte_cyc(1'b0, 1'b0, '0);
    end

    // Asynchronous reset mid-packet, then clean resync
    packet(90, NUM_CH'(1 << 5), 0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", ts_out_valid, 0);
    check("arst_locked", grant_locked, 0);
    check("arst_grant", grant_index, 0);
    check("arst_pkt", packet_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    byte_cyc(1'b0, 1'b0, '0);
    packet(PKT, NUM_CH'(1 << 12), 0);
    check("resync_grant", grant_index, 12);
    check("resync_locked", grant_locked, 1);
    byte_cyc(1'b1, 1'b1, '0);
    check("resync_pkt1", packet_count, 1);
    byte_cyc(1'b0, 1'b0, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
